// File: rtl/oric_tape_pkg.sv
// Shared types and constants for the Oric cassette receive decoder.
package oric_tape_pkg;

  typedef enum logic [1:0] {IDLE, HUNT, LEAD, DATA} dec_state_t;
  typedef enum logic [1:0] {WAIT_START, BITS, PAR, STOP} frame_state_t;

  localparam logic [7:0] LEADER = 8'h16;
  localparam logic [7:0] SYNC   = 8'h24;
  localparam int         PER_W  = 13;

  function automatic int us_to_cycles(input int us, input int clk_hz);
    return us * (clk_hz / 1_000_000);
  endfunction

endpackage

// File: rtl/oric_tape_fifo.sv
// Synchronous FIFO for decoded bytes; a full FIFO still accepts a push when a pop frees a slot.
module oric_tape_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/oric_tape_decoder.sv
// Oric cassette decoder: period-measures tape_in, classifies bits, hunts leader/sync, frames payload bytes.
module oric_tape_decoder
  import oric_tape_pkg::*;
#(
  parameter int CLK_HZ      = 24_000_000,
  parameter int ONE_MAX_US  = 520,
  parameter int ZERO_MAX_US = 900,
  parameter int GAP_US      = 4000,
  parameter int SYNC_MIN    = 3,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       tape_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_perr,
  output logic       carrier,
  output logic       synced,
  output logic       overflow,
  input  logic       clr,
  output logic [3:0] debug_state
);
  localparam int PRESCALE = us_to_cycles(1, CLK_HZ);
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PER_W-1:0] ONE_MAX_C  = PER_W'(ONE_MAX_US);
  localparam logic [PER_W-1:0] ZERO_MAX_C = PER_W'(ZERO_MAX_US);
  localparam logic [PER_W-1:0] GAP_C      = PER_W'(GAP_US);
  localparam logic [3:0]       SYNC_MIN_C = 4'(SYNC_MIN);
  // Three trailing ones, start 0, 0x16 LSB first, odd parity; newest bit at the MSB.
  localparam logic [12:0] LEADER_FRAME = {~^LEADER, LEADER, 1'b0, 3'b111};

  logic             sync1, sync2, dly, rise;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [PER_W-1:0] per_cnt;
  logic             is_bit, bit_val, gap;

  dec_state_t   state, state_n;
  frame_state_t fr, fr_n;
  logic [11:0]  hunt_sr, hunt_sr_n;
  logic [12:0]  window;
  logic [7:0]   shift, shift_n;
  logic [2:0]   bit_idx, bit_idx_n;
  logic [3:0]   lead_cnt, lead_cnt_n;
  logic         armed, armed_n, seen_bit, seen_bit_n, carrier_n;
  logic         push;
  logic [8:0]   push_word, head;
  logic         empty;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      dly     <= 1'b0;
      pre_cnt <= '0;
      per_cnt <= '0;
    end else begin
      sync1   <= tape_in;
      sync2   <= sync1;
      dly     <= sync2;
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (rise)                      per_cnt <= '0;
      else if (tick && per_cnt != '1) per_cnt <= per_cnt + PER_W'(1);
    end
  end

  assign rise    = sync2 & ~dly;
  assign tick    = (pre_cnt == PW'(PRESCALE - 1));
  assign is_bit  = (per_cnt < ZERO_MAX_C);
  assign bit_val = (per_cnt < ONE_MAX_C);
  assign gap     = armed && (per_cnt >= GAP_C);
  assign window  = {bit_val, hunt_sr};

  always_comb begin
    state_n    = state;
    fr_n       = fr;
    hunt_sr_n  = hunt_sr;
    shift_n    = shift;
    bit_idx_n  = bit_idx;
    lead_cnt_n = lead_cnt;
    armed_n    = armed;
    seen_bit_n = seen_bit;
    carrier_n  = carrier;
    push       = 1'b0;
    push_word  = {~^{shift, bit_val}, shift};
    if (!enable || clr || gap) begin
      state_n    = IDLE;
      fr_n       = WAIT_START;
      hunt_sr_n  = '0;
      lead_cnt_n = '0;
      armed_n    = 1'b0;
      seen_bit_n = 1'b0;
      carrier_n  = 1'b0;
    end else if (rise) begin
      // The first edge after IDLE has no preceding edge to measure against.
      armed_n = 1'b1;
      if (armed && !is_bit) begin
        if (state != IDLE) state_n = HUNT;
        fr_n       = WAIT_START;
        hunt_sr_n  = '0;
        lead_cnt_n = '0;
      end else if (armed) begin
        seen_bit_n = 1'b1;
        if (seen_bit) carrier_n = 1'b1;
        case (state)
          IDLE, HUNT: begin
            hunt_sr_n = window[12:1];
            state_n   = HUNT;
            if (window == LEADER_FRAME) begin
              state_n    = LEAD;
              lead_cnt_n = 4'd1;
              fr_n       = STOP;
            end
          end
          default: begin
            case (fr)
              WAIT_START: if (!bit_val) begin
                fr_n      = BITS;
                bit_idx_n = '0;
              end
              BITS: begin
                shift_n   = {bit_val, shift[7:1]};
                bit_idx_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) fr_n = PAR;
              end
              PAR: begin
                fr_n = STOP;
                if (state == DATA) begin
                  push = 1'b1;
                end else if (shift == LEADER) begin
                  if (lead_cnt != 4'd15) lead_cnt_n = lead_cnt + 4'd1;
                end else if (shift == SYNC && lead_cnt >= SYNC_MIN_C) begin
                  state_n = DATA;
                end else begin
                  state_n    = HUNT;
                  fr_n       = WAIT_START;
                  hunt_sr_n  = '0;
                  lead_cnt_n = '0;
                end
              end
              STOP: begin
                // A missing stop bit is tolerated: a 0 here starts the next byte.
                fr_n      = bit_val ? WAIT_START : BITS;
                bit_idx_n = '0;
              end
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fr       <= WAIT_START;
      hunt_sr  <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      lead_cnt <= '0;
      armed    <= 1'b0;
      seen_bit <= 1'b0;
      carrier  <= 1'b0;
    end else begin
      state    <= state_n;
      fr       <= fr_n;
      hunt_sr  <= hunt_sr_n;
      shift    <= shift_n;
      bit_idx  <= bit_idx_n;
      lead_cnt <= lead_cnt_n;
      armed    <= armed_n;
      seen_bit <= seen_bit_n;
      carrier  <= carrier_n;
    end
  end

  assign synced      = (state == DATA);
  assign debug_state = {fr, state};

  oric_tape_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .clr      (clr),
    .push     (push),
    .push_data(push_word),
    .pop      (out_ready),
    .head     (head),
    .empty    (empty),
    .overflow (overflow)
  );

  assign out_valid = !empty;
  assign out_perr  = head[8];
  assign out_data  = head[7:0];

endmodule
